ibex_uarch_stall_tracker: RTL and testbench
===========================================

Name: ibex_uarch_stall_tracker

Overview:
- DV-side monitor that sits directly downstream of the uarch functional-coverage interface.
- Consumes the per-cycle ID-stage valid, instruction and stall-cause signals.
- Folds them into one record per completed ID-stage instruction, holding per-cause stall-cycle counts.
- Buffers records in a small FIFO drained by the coverage collector / scoreboard over valid/ready.

Parameters:
- CntW, 8, width of each saturating stall counter.
- FifoDepth, 4, record FIFO entries; power of two, at least 2.
- RecordAll, 0, 1: emit a record for every completed instruction; 0: only for instructions with total stall > 0.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- valid_id_i  in  1  ID stage holds a valid instruction
- instr_id_i  in  32  instruction word in ID
- stall_ld_hz_i  in  1  load-hazard stall
- stall_mem_i  in  1  memory stall
- stall_multdiv_i  in  1  mult/div stall
- stall_branch_i  in  1  branch stall
- stall_jump_i  in  1  jump stall
- rec_valid_o  out  1  record available
- rec_ready_i  in  1  consumer accepts record
- rec_instr_o  out  32  instruction of record
- rec_cnt_o  out  5*CntW  per-cause counts; index order ld_hz, mem, multdiv, branch, jump (LSB first)
- rec_total_o  out  CntW  total stall cycles
- drop_cnt_o  out  16  records dropped because the FIFO was full (saturating)
- kill_cnt_o  out  16  stalled instructions removed from ID without completing (saturating)
- overflow_o  out  1  sticky: set on first drop

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0, FIFO empty, accumulators 0, FSM in IDLE.
- Derived signals:
  - any_stall = OR of the five stall inputs.
  - done = valid_id_i & ~any_stall.
- FSM states IDLE and STALL:
  - IDLE, valid_id_i & any_stall: load accumulators with the current cycle's causes (each asserted cause = 1, total = 1), latch instr_id_i, go to STALL.
  - IDLE, done: push a record only if RecordAll=1 (all counts 0); stay in IDLE.
  - STALL, valid_id_i & any_stall: each asserted cause counter +1; total +1 once per cycle regardless of how many causes are asserted. All increments saturate at 2^CntW-1.
  - STALL, done: push the record (latched instr, accumulated counts); go to IDLE.
  - STALL, ~valid_id_i: discard the accumulators, kill_cnt_o +1 (saturating), no record, go to IDLE.
  - STALL, instr_id_i differs from the latched value while valid_id_i: treat as kill of the old instruction, then reload the accumulators for the new one in the same cycle.
- Latency: a record is visible on rec_* the cycle after its done cycle when the FIFO was empty; no combinational path from inputs to outputs.
- FIFO and handshake:
  - rec_valid_o = FIFO not empty.
  - Pop on rec_valid_o & rec_ready_i.
  - rec_* must remain stable while rec_valid_o & ~rec_ready_i.
  - Simultaneous push and pop when full: the pop frees the slot, the push succeeds, no drop.
  - Push when full and not popping: record dropped, drop_cnt_o +1 (saturating at 16'hFFFF), overflow_o set.
  - Read and write pointers wrap modulo FifoDepth; full/empty are distinguished by an extra pointer MSB.
- overflow_o clears only on reset.
- Reset mid-episode or mid-handshake: all state cleared immediately; no partial record survives.

Optional Feature:
- Macro IBEX_UARCH_STALL_HIST_EN.
- When defined:
  - Adds output hist_o [8*16-1:0]: eight 16-bit saturating bins of rec_total per pushed record.
  - Bin index is min(floor(log2(total)), 7); a total of 0 goes to bin 0 (RecordAll=1 only).
  - Bins update on push, including dropped records.
- When undefined: port and logic absent; the rest of the behaviour is identical.

Decomposition:
- Package ibex_uarch_fcov_pkg:
  - stall_cause_e (LD_HZ, MEM, MULTDIV, BRANCH, JUMP) and NumStallCauses = 5.
  - tracker_state_e (IDLE, STALL).
  - Parameterised packed stall_rec_t {instr, cnt[5], total}.
- Sub-module ibex_uarch_rec_fifo: a generic synchronous FIFO with the same clk_i/rst_i, holding stall_rec_t, with full/empty outputs.

Test Plan:
- Single mem stall: valid_id=1, instr=32'h0000_2083, stall_mem for 3 cycles, then 1 clean cycle, ready=1 -> one record: cnt_mem=3, total=3, other counts 0, rec_valid high 1 cycle after done.
- Concurrent causes: ld_hz and mem both high for 2 cycles, then mem alone for 1, then done -> ld_hz=2, mem=3, total=3.
- Saturation: CntW=8, stall_multdiv held 300 cycles, then done -> multdiv=255, total=255.
- Kill: 4 stall cycles, then valid_id=0 -> no record, kill_cnt_o=1, FSM in IDLE.
- Backpressure and overflow: FifoDepth=4, ready=0, 6 stalled instructions complete -> 4 records held stable, drop_cnt_o=2, overflow_o=1. Then ready=1 -> 4 records drained in order, overflow_o remains 1.
- Full with simultaneous pop and push: FIFO full, ready=1 on the same cycle as a done -> no drop, occupancy stays 4.

Source files
------------

// File: rtl/ibex_uarch_fcov_pkg.sv
// Shared types for the uarch stall tracker: stall causes, tracker FSM states, histogram helper.
// The record struct depends on the counter width, so the top module declares it from CntW.
package ibex_uarch_fcov_pkg;

    localparam int unsigned NumStallCauses = 5;
    localparam int unsigned InstrW         = 32;
    localparam int unsigned HistBins       = 8;
    localparam int unsigned HistW          = 16;

    typedef enum logic [2:0] {
        LD_HZ   = 3'd0,
        MEM     = 3'd1,
        MULTDIV = 3'd2,
        BRANCH  = 3'd3,
        JUMP    = 3'd4
    } stall_cause_e;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } tracker_state_e;

    // Histogram bin = floor(log2(total)) clamped to the last bin; zero lands in bin 0.
    function automatic logic [2:0] hist_bin(input logic [31:0] total);
        logic [2:0] bin;
        bin = '0;
        for (int i = 0; i < 32; i++) begin
            if (total[i]) begin
                bin = (i > 7) ? 3'd7 : 3'(i);
            end
        end
        return bin;
    endfunction

endpackage

// File: rtl/ibex_uarch_rec_fifo.sv
// Generic synchronous record FIFO; pointers carry an extra MSB to tell full from empty.
// A pop on a full FIFO frees the slot for a push in the same cycle.
module ibex_uarch_rec_fifo
    import ibex_uarch_fcov_pkg::*;
#(
    parameter type         rec_t = logic [7:0],
    parameter int unsigned Depth = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  rec_t wdata_i,
    input  logic pop_i,
    output rec_t rdata_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

    rec_t [Depth-1:0] mem_q, mem_d;
    logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
    logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
    logic             wr_en, rd_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                     (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign rd_en   = pop_i & ~empty_o;
    assign wr_en   = push_i & (~full_o | rd_en);
    assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q[AddrW-1:0]] = wdata_i;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/ibex_uarch_stall_tracker.sv
// Folds per-cycle ID-stage stall causes into one record per completed instruction and queues it.
// Define IBEX_UARCH_STALL_HIST_EN to add hist_o, a log2 histogram of pushed record totals.
module ibex_uarch_stall_tracker
    import ibex_uarch_fcov_pkg::*;
#(
    parameter int unsigned CntW      = 8,
    parameter int unsigned FifoDepth = 4,
    parameter bit          RecordAll = 1'b0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           valid_id_i,
    input  logic [InstrW-1:0]              instr_id_i,
    input  logic                           stall_ld_hz_i,
    input  logic                           stall_mem_i,
    input  logic                           stall_multdiv_i,
    input  logic                           stall_branch_i,
    input  logic                           stall_jump_i,
    output logic                           rec_valid_o,
    input  logic                           rec_ready_i,
    output logic [InstrW-1:0]              rec_instr_o,
    output logic [NumStallCauses*CntW-1:0] rec_cnt_o,
    output logic [CntW-1:0]                rec_total_o,
    output logic [15:0]                    drop_cnt_o,
    output logic [15:0]                    kill_cnt_o,
    output logic                           overflow_o,
    output tracker_state_e                 dbg_state_o
`ifdef IBEX_UARCH_STALL_HIST_EN
    ,output logic [HistBins*HistW-1:0]     hist_o
`endif
);

    typedef struct packed {
        logic [InstrW-1:0]                        instr;
        logic [NumStallCauses-1:0][CntW-1:0]      cnt;
        logic [CntW-1:0]                          total;
    } stall_rec_t;

    tracker_state_e                      state_q, state_d;
    logic [NumStallCauses-1:0][CntW-1:0] acc_cnt_q, acc_cnt_d;
    logic [CntW-1:0]                     acc_total_q, acc_total_d;
    logic [InstrW-1:0]                   instr_q, instr_d;
    logic [15:0]                         kill_cnt_q, kill_cnt_d;
    logic [15:0]                         drop_cnt_q, drop_cnt_d;
    logic                                overflow_q, overflow_d;

    logic [NumStallCauses-1:0] cause;
    logic                      any_stall, done, kill, push, pop, drop;
    logic                      fifo_full, fifo_empty;
    stall_rec_t                push_rec, head_rec;

    // Bit order follows stall_cause_e: ld_hz in bit 0 up to jump in bit 4.
    assign cause     = {stall_jump_i, stall_branch_i, stall_multdiv_i, stall_mem_i, stall_ld_hz_i};
    assign any_stall = |cause;
    assign done      = valid_id_i & ~any_stall;

    always_comb begin
        state_d     = state_q;
        acc_cnt_d   = acc_cnt_q;
        acc_total_d = acc_total_q;
        instr_d     = instr_q;
        push        = 1'b0;
        push_rec    = '0;
        kill        = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_id_i && any_stall) begin
                    for (int i = 0; i < NumStallCauses; i++) acc_cnt_d[i] = CntW'(cause[i]);
                    acc_total_d = CntW'(1);
                    instr_d     = instr_id_i;
                    state_d     = STALL;
                end else if (done && RecordAll) begin
                    push           = 1'b1;
                    push_rec.instr = instr_id_i;
                end
            end
            STALL: begin
                if (!valid_id_i) begin
                    kill        = 1'b1;
                    acc_cnt_d   = '0;
                    acc_total_d = '0;
                    state_d     = IDLE;
                end else if (instr_id_i != instr_q) begin
                    // A new instruction replaced the stalled one: count the old one as killed.
                    kill = 1'b1;
                    if (any_stall) begin
                        for (int i = 0; i < NumStallCauses; i++) acc_cnt_d[i] = CntW'(cause[i]);
                        acc_total_d = CntW'(1);
                        instr_d     = instr_id_i;
                    end else begin
                        acc_cnt_d   = '0;
                        acc_total_d = '0;
                        state_d     = IDLE;
                        if (RecordAll) begin
                            push           = 1'b1;
                            push_rec.instr = instr_id_i;
                        end
                    end
                end else if (any_stall) begin
                    for (int i = 0; i < NumStallCauses; i++) begin
                        if (cause[i] && (acc_cnt_q[i] != '1)) acc_cnt_d[i] = acc_cnt_q[i] + 1'b1;
                    end
                    if (acc_total_q != '1) acc_total_d = acc_total_q + 1'b1;
                end else begin
                    push           = 1'b1;
                    push_rec.instr = instr_q;
                    push_rec.cnt   = acc_cnt_q;
                    push_rec.total = acc_total_q;
                    acc_cnt_d      = '0;
                    acc_total_d    = '0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop  = ~fifo_empty & rec_ready_i;
    assign drop = push & fifo_full & ~pop;

    always_comb begin
        kill_cnt_d = kill_cnt_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q | drop;
        if (kill && (kill_cnt_q != 16'hFFFF)) kill_cnt_d = kill_cnt_q + 16'd1;
        if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            acc_cnt_q   <= '0;
            acc_total_q <= '0;
            instr_q     <= '0;
            kill_cnt_q  <= '0;
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_cnt_q   <= acc_cnt_d;
            acc_total_q <= acc_total_d;
            instr_q     <= instr_d;
            kill_cnt_q  <= kill_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    ibex_uarch_rec_fifo #(
        .rec_t (stall_rec_t),
        .Depth (FifoDepth)
    ) u_rec_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdata_i (push_rec),
        .pop_i   (pop),
        .rdata_o (head_rec),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rec_valid_o = ~fifo_empty;
    assign rec_instr_o = head_rec.instr;
    assign rec_cnt_o   = head_rec.cnt;
    assign rec_total_o = head_rec.total;
    assign drop_cnt_o  = drop_cnt_q;
    assign kill_cnt_o  = kill_cnt_q;
    assign overflow_o  = overflow_q;
    assign dbg_state_o = state_q;

`ifdef IBEX_UARCH_STALL_HIST_EN
    logic [HistBins-1:0][HistW-1:0] hist_q, hist_d;
    logic [2:0]                     hist_idx;

    // Every push attempt is binned, dropped records included.
    always_comb begin
        hist_d   = hist_q;
        hist_idx = hist_bin(32'(push_rec.total));
        if (push && (hist_q[hist_idx] != '1)) hist_d[hist_idx] = hist_q[hist_idx] + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) hist_q <= '0;
        else       hist_q <= hist_d;
    end

    assign hist_o = hist_q;
`endif

endmodule

// File: tb/tb_ibex_uarch_stall_tracker.sv
// Directed self-checking bench for ibex_uarch_stall_tracker (default parameters).
// Inputs change #1 after the rising edge; outputs are checked there too.
module tb_ibex_uarch_stall_tracker;
    import ibex_uarch_fcov_pkg::*;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           valid_id = 1'b0;
    logic [31:0]    instr_id = '0;
    logic [4:0]     causes = '0;    // {jump, branch, multdiv, mem, ld_hz}
    logic           rdy = 1'b0;
    logic           rec_valid;
    logic [31:0]    rec_instr;
    logic [39:0]    rec_cnt;
    logic [7:0]     rec_total;
    logic [15:0]    drop_cnt, kill_cnt;
    logic           overflow;
    tracker_state_e dbg_state;
`ifdef IBEX_UARCH_STALL_HIST_EN
    logic [127:0]   hist;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    ibex_uarch_stall_tracker dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .valid_id_i      (valid_id),
        .instr_id_i      (instr_id),
        .stall_ld_hz_i   (causes[0]),
        .stall_mem_i     (causes[1]),
        .stall_multdiv_i (causes[2]),
        .stall_branch_i  (causes[3]),
        .stall_jump_i    (causes[4]),
        .rec_valid_o     (rec_valid),
        .rec_ready_i     (rdy),
        .rec_instr_o     (rec_instr),
        .rec_cnt_o       (rec_cnt),
        .rec_total_o     (rec_total),
        .drop_cnt_o      (drop_cnt),
        .kill_cnt_o      (kill_cnt),
        .overflow_o      (overflow),
        .dbg_state_o     (dbg_state)
`ifdef IBEX_UARCH_STALL_HIST_EN
        ,.hist_o         (hist)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [4:0] c);
        valid_id = v;
        instr_id = ins;
        causes   = c;
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0, 5'b0);
        rdy = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        vec_cnt++; if (rec_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_rec_valid got %b exp 0", rec_valid); end
        vec_cnt++; if (rec_instr !== 32'h0) begin err_cnt++; $display("FAIL reset_rec_instr got %h exp 0", rec_instr); end
        vec_cnt++; if (rec_total !== 8'h0) begin err_cnt++; $display("FAIL reset_rec_total got %h exp 0", rec_total); end
        vec_cnt++; if (drop_cnt !== 16'h0) begin err_cnt++; $display("FAIL reset_drop got %h exp 0", drop_cnt); end
        vec_cnt++; if (kill_cnt !== 16'h0) begin err_cnt++; $display("FAIL reset_kill got %h exp 0", kill_cnt); end
        vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        vec_cnt++; if (dbg_state !== IDLE) begin err_cnt++; $display("FAIL reset_state got %0d exp IDLE", dbg_state); end
    endtask

    task automatic test_single_mem();
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0000_2083, 5'b00010);
            step();
        end
        vec_cnt++; if (dbg_state !== STALL) begin err_cnt++; $display("FAIL mem_state got %0d exp STALL", dbg_state); end
        drive(1'b1, 32'h0000_2083, 5'b00000);
        #1;
        vec_cnt++; if (rec_valid !== 1'b0) begin err_cnt++; $display("FAIL mem_valid_in_done_cycle got %b exp 0", rec_valid); end
        step();
        drive(1'b0, 32'h0, 5'b0);
        vec_cnt++; if (rec_valid !== 1'b1) begin err_cnt++; $display("FAIL mem_valid got %b exp 1", rec_valid); end
        vec_cnt++; if (rec_instr !== 32'h0000_2083) begin err_cnt++; $display("FAIL mem_instr got %h exp 00002083", rec_instr); end
        vec_cnt++; if (rec_cnt !== {8'd0, 8'd0, 8'd0, 8'd3, 8'd0}) begin err_cnt++; $display("FAIL mem_cnt got %h exp %h", rec_cnt, {8'd0, 8'd0, 8'd0, 8'd3, 8'd0}); end
        vec_cnt++; if (rec_total !== 8'd3) begin err_cnt++; $display("FAIL mem_total got %0d exp 3", rec_total); end
        step();
        vec_cnt++; if (rec_valid !== 1'b0) begin err_cnt++; $display("FAIL mem_popped got %b exp 0", rec_valid); end
    endtask

    task automatic test_concurrent();
        rdy = 1'b1;
        drive(1'b1, 32'h0000_0013, 5'b00011); step();
        drive(1'b1, 32'h0000_0013, 5'b00011); step();
        drive(1'b1, 32'h0000_0013, 5'b00010); step();
        drive(1'b1, 32'h0000_0013, 5'b00000); step();
        drive(1'b0, 32'h0, 5'b0);
        vec_cnt++; if (rec_valid !== 1'b1) begin err_cnt++; $display("FAIL conc_valid got %b exp 1", rec_valid); end
        vec_cnt++; if (rec_cnt !== {8'd0, 8'd0, 8'd0, 8'd3, 8'd2}) begin err_cnt++; $display("FAIL conc_cnt got %h exp %h", rec_cnt, {8'd0, 8'd0, 8'd0, 8'd3, 8'd2}); end
        vec_cnt++; if (rec_total !== 8'd3) begin err_cnt++; $display("FAIL conc_total got %0d exp 3", rec_total); end
        step();
    endtask

    task automatic test_saturation();
        rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 32'h0220_80b3, 5'b00100);
            step();
        end
        drive(1'b1, 32'h0220_80b3, 5'b00000); step();
        drive(1'b0, 32'h0, 5'b0);
        vec_cnt++; if (rec_cnt !== {8'd0, 8'd0, 8'd255, 8'd0, 8'd0}) begin err_cnt++; $display("FAIL sat_cnt got %h exp %h", rec_cnt, {8'd0, 8'd0, 8'd255, 8'd0, 8'd0}); end
        vec_cnt++; if (rec_total !== 8'd255) begin err_cnt++; $display("FAIL sat_total got %0d exp 255", rec_total); end
        step();
    endtask

    task automatic test_kill();
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h0000_a003, 5'b00001);
            step();
        end
        drive(1'b0, 32'h0, 5'b0); step();
        vec_cnt++; if (kill_cnt !== 16'd1) begin err_cnt++; $display("FAIL kill_cnt got %0d exp 1", kill_cnt); end
        vec_cnt++; if (dbg_state !== IDLE) begin err_cnt++; $display("FAIL kill_state got %0d exp IDLE", dbg_state); end
        step();
        vec_cnt++; if (rec_valid !== 1'b0) begin err_cnt++; $display("FAIL kill_no_record got %b exp 0", rec_valid); end
    endtask

    task automatic test_instr_change();
        rdy = 1'b1;
        drive(1'b1, 32'h0000_0033, 5'b00001); step();
        drive(1'b1, 32'h0000_0033, 5'b00001); step();
        drive(1'b1, 32'h0000_0063, 5'b01000); step();
        vec_cnt++; if (kill_cnt !== 16'd2) begin err_cnt++; $display("FAIL chg_kill got %0d exp 2", kill_cnt); end
        vec_cnt++; if (dbg_state !== STALL) begin err_cnt++; $display("FAIL chg_state got %0d exp STALL", dbg_state); end
        drive(1'b1, 32'h0000_0063, 5'b00000); step();
        drive(1'b0, 32'h0, 5'b0);
        vec_cnt++; if (rec_instr !== 32'h0000_0063) begin err_cnt++; $display("FAIL chg_instr got %h exp 00000063", rec_instr); end
        vec_cnt++; if (rec_cnt !== {8'd0, 8'd1, 8'd0, 8'd0, 8'd0}) begin err_cnt++; $display("FAIL chg_cnt got %h exp %h", rec_cnt, {8'd0, 8'd1, 8'd0, 8'd0, 8'd0}); end
        vec_cnt++; if (rec_total !== 8'd1) begin err_cnt++; $display("FAIL chg_total got %0d exp 1", rec_total); end
        step();
    endtask

    task automatic test_overflow();
        rdy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 32'h100 + 32'(k), 5'b01000); step();
            drive(1'b1, 32'h100 + 32'(k), 5'b00000); step();
            if (k < 4) exp_q.push_back(32'h100 + 32'(k));
            if (k == 3) begin
                vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL ovf_not_yet got %b exp 0", overflow); end
                vec_cnt++; if (drop_cnt !== 16'd0) begin err_cnt++; $display("FAIL ovf_drop_at_full got %0d exp 0", drop_cnt); end
            end
        end
        drive(1'b0, 32'h0, 5'b0);
        vec_cnt++; if (drop_cnt !== 16'd2) begin err_cnt++; $display("FAIL ovf_drop got %0d exp 2", drop_cnt); end
        vec_cnt++; if (overflow !== 1'b1) begin err_cnt++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        vec_cnt++; if (rec_instr !== 32'h100) begin err_cnt++; $display("FAIL ovf_head_stable got %h exp 00000100", rec_instr); end
        step();
        vec_cnt++; if (rec_instr !== 32'h100) begin err_cnt++; $display("FAIL ovf_head_hold got %h exp 00000100", rec_instr); end
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            vec_cnt++; if (rec_valid !== 1'b1 || rec_instr !== e) begin err_cnt++; $display("FAIL ovf_drain valid %b instr %h exp instr %h", rec_valid, rec_instr, e); end
            step();
        end
        vec_cnt++; if (rec_valid !== 1'b0) begin err_cnt++; $display("FAIL ovf_drained got %b exp 0", rec_valid); end
        vec_cnt++; if (overflow !== 1'b1) begin err_cnt++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    endtask

    task automatic test_full_pop_push();
        int pops;
        rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h200 + 32'(k), 5'b10000); step();
            drive(1'b1, 32'h200 + 32'(k), 5'b00000); step();
            exp_q.push_back(32'h200 + 32'(k));
        end
        drive(1'b1, 32'h204, 5'b10000); step();
        drive(1'b1, 32'h204, 5'b00000);
        rdy = 1'b1;
        step();
        void'(exp_q.pop_front());
        exp_q.push_back(32'h204);
        rdy = 1'b0;
        drive(1'b0, 32'h0, 5'b0);
        vec_cnt++; if (drop_cnt !== 16'd2) begin err_cnt++; $display("FAIL fpp_drop got %0d exp 2", drop_cnt); end
        vec_cnt++; if (rec_instr !== 32'h201) begin err_cnt++; $display("FAIL fpp_head got %h exp 00000201", rec_instr); end
        rdy = 1'b1;
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            if (rec_valid === 1'b1) begin
                logic [31:0] e;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdead_beef;
                vec_cnt++; if (rec_instr !== e) begin err_cnt++; $display("FAIL fpp_order got %h exp %h", rec_instr, e); end
                pops++;
            end
            step();
        end
        vec_cnt++; if (pops != 4) begin err_cnt++; $display("FAIL fpp_occupancy got %0d exp 4", pops); end
    endtask

    task automatic test_reset_mid();
        rdy = 1'b0;
        drive(1'b1, 32'h300, 5'b00010); step();
        drive(1'b1, 32'h300, 5'b00000); step();
        drive(1'b1, 32'h301, 5'b00010); step();
        #3;
        rst = 1'b1;
        #1;
        vec_cnt++; if (rec_valid !== 1'b0) begin err_cnt++; $display("FAIL rmid_valid got %b exp 0", rec_valid); end
        vec_cnt++; if (dbg_state !== IDLE) begin err_cnt++; $display("FAIL rmid_state got %0d exp IDLE", dbg_state); end
        vec_cnt++; if (overflow !== 1'b0 || drop_cnt !== 16'd0 || kill_cnt !== 16'd0) begin err_cnt++; $display("FAIL rmid_counters ovf %b drop %0d kill %0d exp 0 0 0", overflow, drop_cnt, kill_cnt); end
        drive(1'b0, 32'h0, 5'b0);
        step();
        rst = 1'b0;
        step();
        vec_cnt++; if (rec_valid !== 1'b0 || rec_instr !== 32'h0) begin err_cnt++; $display("FAIL rmid_after valid %b instr %h exp 0 0", rec_valid, rec_instr); end
    endtask

    initial begin
        test_reset();
        test_single_mem();
        test_concurrent();
        test_saturation();
        test_kill();
        test_instr_change();
        test_overflow();
        test_full_pop_push();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
